// File: rtl/match_scheduler.sv
// Sequencing controller for the vocabulary matcher: scans zero-separated words,
// runs one matcher job per word with a timeout, and streams per-word results.
`timescale 1ns/1ps
module match_scheduler #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] in_limit,
  input  logic [ADDR_WIDTH-1:0] vocab_start,
  input  logic [ADDR_WIDTH-1:0] vocab_end,
  output logic [ADDR_WIDTH-1:0] scan_addr,
  input  logic [DATA_WIDTH-1:0] scan_data,
  output logic                  m_rst_n,
  output logic                  m_cs,
  output logic [ADDR_WIDTH-1:0] m_vocab_start,
  output logic [ADDR_WIDTH-1:0] m_vocab_end,
  output logic [ADDR_WIDTH-1:0] m_input_start,
  input  logic                  m_found,
  input  logic                  m_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  res_found,
  output logic                  res_timeout,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH:0]   found_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_LAUNCH, S_RUN, S_RESULT, S_SKIP, S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_scan_addr;
  logic [ADDR_WIDTH-1:0] r_in_limit;
  logic [ADDR_WIDTH-1:0] r_vocab_start;
  logic [ADDR_WIDTH-1:0] r_vocab_end;
  logic [ADDR_WIDTH-1:0] r_input_start;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [ADDR_WIDTH:0]   r_found_count;
  logic [TW-1:0]         r_tcnt;
  logic                  r_m_rst_n;
  logic                  r_m_cs;
  logic                  r_res_valid;
  logic                  r_res_found;
  logic                  r_res_timeout;
  logic                  r_done;

  logic                  w_at_limit;
  logic                  w_sep;
  logic [TW-1:0]         w_tcnt_next;
  logic                  w_tmo;

  assign w_at_limit  = (r_scan_addr == r_in_limit);
  assign w_sep       = (scan_data == '0);
  assign w_tcnt_next = r_tcnt + 1'b1;
  assign w_tmo       = (w_tcnt_next == TW'(TIMEOUT));

  // m_rst_n/m_cs are set on the edge entering RUN and cleared on the edge
  // leaving it, so both come straight from flops with no decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_scan_addr   <= '0;
      r_in_limit    <= '0;
      r_vocab_start <= '0;
      r_vocab_end   <= '0;
      r_input_start <= '0;
      r_word_count  <= '0;
      r_found_count <= '0;
      r_tcnt        <= '0;
      r_m_rst_n     <= 1'b0;
      r_m_cs        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_found   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_m_rst_n <= 1'b0;
          r_m_cs    <= 1'b0;
          if (start) begin
            r_scan_addr   <= in_base;
            r_in_limit    <= in_limit;
            r_vocab_start <= vocab_start;
            r_vocab_end   <= vocab_end;
            r_word_count  <= '0;
            r_found_count <= '0;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_at_limit) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_sep) begin
            r_scan_addr <= r_scan_addr + 1'b1;
          end else begin
            r_input_start <= r_scan_addr;
            r_word_count  <= r_word_count + 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tcnt    <= '0;
          r_m_rst_n <= 1'b1;
          r_m_cs    <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_tcnt <= w_tcnt_next;
          // A done arriving on the timeout cycle takes priority.
          if (m_done || w_tmo) begin
            r_res_found   <= m_done ? m_found : 1'b0;
            r_res_timeout <= ~m_done;
            r_res_valid   <= 1'b1;
            r_m_rst_n     <= 1'b0;
            r_m_cs        <= 1'b0;
            r_state       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_res_found) r_found_count <= r_found_count + 1'b1;
            r_state <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (w_at_limit) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_sep) begin
            r_scan_addr <= r_scan_addr + 1'b1;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scan_addr     = r_scan_addr;
  assign m_rst_n       = r_m_rst_n;
  assign m_cs          = r_m_cs;
  assign m_vocab_start = r_vocab_start;
  assign m_vocab_end   = r_vocab_end;
  assign m_input_start = r_input_start;
  assign res_valid     = r_res_valid;
  assign res_addr      = r_input_start;
  assign res_found     = r_res_found;
  assign res_timeout   = r_res_timeout;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign word_count    = r_word_count;
  assign found_count   = r_found_count;

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a behavioural matcher stub that
// recognises the single vocabulary word "cat".
`timescale 1ns/1ps
module tb_match_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  in_base = '0, in_limit = '0, vocab_start = '0, vocab_end = '0;
  logic [3:0]  scan_addr;
  logic [7:0]  scan_data;
  logic        m_rst_n, m_cs, m_found, m_done;
  logic [3:0]  m_vocab_start, m_vocab_end, m_input_start;
  logic        res_valid, res_found, res_timeout;
  logic        res_ready = 1'b1;
  logic [3:0]  res_addr;
  logic        busy, done;
  logic [4:0]  word_count, found_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  match_scheduler #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_base(in_base), .in_limit(in_limit),
    .vocab_start(vocab_start), .vocab_end(vocab_end),
    .scan_addr(scan_addr), .scan_data(scan_data),
    .m_rst_n(m_rst_n), .m_cs(m_cs),
    .m_vocab_start(m_vocab_start), .m_vocab_end(m_vocab_end),
    .m_input_start(m_input_start), .m_found(m_found), .m_done(m_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
    .res_found(res_found), .res_timeout(res_timeout),
    .busy(busy), .done(done), .word_count(word_count), .found_count(found_count)
  );

  // Input buffer and matcher stub
  logic [15:0][7:0] cfg_mem = '0;
  int               st_lat  = 3;
  bit               st_hang = 1'b0;
  int               scnt;
  logic [3:0]       a1, a2, a3;

  assign scan_data = cfg_mem[scan_addr];

  always @(posedge clk) begin
    if (!m_rst_n) scnt <= 0;
    else if (m_cs) scnt <= scnt + 1;
  end

  always_comb begin
    a1 = m_input_start + 4'd1;
    a2 = m_input_start + 4'd2;
    a3 = m_input_start + 4'd3;
    m_found = (cfg_mem[m_input_start] == 8'h63) && (cfg_mem[a1] == 8'h61) &&
              (cfg_mem[a2] == 8'h74) && (cfg_mem[a3] == 8'h00);
    m_done  = m_cs && !st_hang && (scnt >= st_lat - 1);
  end

  typedef struct {
    logic [15:0][7:0] mem;
    logic [3:0]       base, limit;
    int               lat;
    bit               hang;
    int               nres;
    logic [3:0][3:0]  eaddr;
    logic [3:0]       efound, etout;
    logic [4:0]       wc, fc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0][7:0] mk(input string s);
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) begin
      if (i < s.len() && s[i] != 8'h2E) r[i] = s[i];
      else r[i] = '0;
    end
    return r;
  endfunction

  function automatic void setv(input int i, input string s, input logic [3:0] b, input logic [3:0] l,
                               input int lat, input bit hang, input int n, input logic [15:0] ea,
                               input logic [3:0] ef, input logic [3:0] et,
                               input logic [4:0] wc, input logic [4:0] fc);
    vecs[i].mem = mk(s);   vecs[i].base = b;   vecs[i].limit = l;
    vecs[i].lat = lat;     vecs[i].hang = hang; vecs[i].nres = n;
    vecs[i].eaddr = ea;    vecs[i].efound = ef; vecs[i].etout = et;
    vecs[i].wc = wc;       vecs[i].fc = fc;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    cfg_mem = v.mem; st_lat = v.lat; st_hang = v.hang;
    in_base = v.base; in_limit = v.limit;
    vocab_start = 4'h3; vocab_end = 4'h9;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k = 0;
    bit seen = 1'b0;
    setup(v);
    res_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 400 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (res_valid) begin
        if (k < v.nres) begin
          chk($sformatf("v%0d_addr%0d", idx, k), 32'(res_addr), 32'(v.eaddr[k]));
          chk($sformatf("v%0d_found%0d", idx, k), 32'(res_found), 32'(v.efound[k]));
          chk($sformatf("v%0d_tout%0d", idx, k), 32'(res_timeout), 32'(v.etout[k]));
        end else begin
          chk($sformatf("v%0d_extra_result", idx), 32'(res_valid), 0);
        end
        k++;
      end
      if (done) seen = 1'b1;
    end
    chk($sformatf("v%0d_done", idx), 32'(seen), 1);
    chk($sformatf("v%0d_nres", idx), k, v.nres);
    chk($sformatf("v%0d_word_count", idx), 32'(word_count), 32'(v.wc));
    chk($sformatf("v%0d_found_count", idx), 32'(found_count), 32'(v.fc));
    chk($sformatf("v%0d_vocab", idx), 32'({m_vocab_start, m_vocab_end}), 32'h39);
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int runc;
    logic got;

    //   buffer              base   limit  lat hang n  addrs     found    tout     wc  fc
    setv(0, "cat.dog.",         4'd0,  4'd8, 3, 0, 2, 16'h0040, 4'b0001, 4'b0000, 2, 1);
    setv(1, "..cat...dog.cat.", 4'd1,  4'd0, 1, 0, 3, 16'h0C82, 4'b0101, 4'b0000, 3, 2);
    setv(2, "B.............A.", 4'd14, 4'd2, 2, 0, 2, 16'h000E, 4'b0000, 4'b0000, 2, 0);
    setv(3, "dogcat..",         4'd3,  4'd6, 3, 0, 1, 16'h0003, 4'b0001, 4'b0000, 1, 1);
    setv(4, "cat.",             4'd0,  4'd4, 3, 1, 1, 16'h0000, 4'b0000, 4'b0001, 1, 0);
    setv(5, "cat.",             4'd0,  4'd4, 8, 0, 1, 16'h0000, 4'b0001, 4'b0000, 1, 1);
    setv(6, "",                 4'd5,  4'd5, 3, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);

    // Reset state
    #2;
    chk("rst_m_rst_n", 32'(m_rst_n), 0);
    chk("rst_ctl", 32'({m_cs, res_valid, busy, done, res_found, res_timeout}), 0);
    chk("rst_addrs", 32'({scan_addr, m_input_start, m_vocab_start, m_vocab_end, res_addr}), 0);
    chk("rst_counts", 32'({word_count, found_count}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Empty buffer timing: done exactly two cycles after start
    setup(vecs[6]);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    chk("empty_c1_busy", 32'(busy), 1);
    chk("empty_c1_done", 32'(done), 0);
    @(negedge clk);
    chk("empty_c2_done", 32'(done), 1);
    chk("empty_c2_quiet", 32'({res_valid, m_cs}), 0);
    @(negedge clk);
    chk("empty_c3_done", 32'(done), 0);
    chk("empty_c3_busy", 32'(busy), 0);

    // Timeout: exactly TIMEOUT cycles of RUN, then matcher held in reset
    setup(vecs[4]);
    res_ready = 1'b0;
    runc = 0;
    got = 1'b0;
    pulse_start();
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else if (m_cs) runc++;
    end
    chk("tmo_valid", 32'(got), 1);
    chk("tmo_run_cycles", runc, 8);
    chk("tmo_flags", 32'({res_timeout, res_found}), 32'b10);
    chk("tmo_m_rst_n", 32'(m_rst_n), 0);
    res_ready = 1'b1;
    wait_done("tmo_done");
    chk("tmo_found_count", 32'(found_count), 0);

    // Backpressure, with a start pulse while busy that must be ignored
    setup(vecs[0]);
    res_ready = 1'b0;
    got = 1'b0;
    pulse_start();
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    chk("bp_valid", 32'(got), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), 32'({res_valid, res_addr, res_found, m_rst_n}), 32'b1_0000_1_0);
      chk($sformatf("bp_fc%0d", i), 32'(found_count), 0);
      start = (i == 3);
      if (i == 3) begin in_base = 4'd9; vocab_start = 4'd7; end
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_fc", 32'(found_count), 1);
    chk("bp_handshake_valid", 32'(res_valid), 0);
    wait_done("bp_done");
    chk("bp_word_count", 32'(word_count), 2);
    chk("bp_vocab_stable", 32'(m_vocab_start), 3);

    // Reset during RUN
    setup(vecs[4]);
    got = 1'b0;
    pulse_start();
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (m_cs) got = 1'b1;
    end
    chk("mid_reached_run", 32'(got), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m", 32'({m_rst_n, m_cs}), 0);
    chk("mid_rst_state", 32'({busy, res_valid, done}), 0);
    chk("mid_rst_regs", 32'({scan_addr, word_count, m_input_start}), 0);
    @(negedge clk);
    chk("mid_rst_nodone", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_idle", 32'({busy, done}), 0);
    run_vec(7, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_scheduler.md
# match_scheduler

Sequencing controller for the vocabulary `matcher`. It scans an input buffer of zero-separated words and launches one `matcher` job per word. It captures each job's found/not-found result, or a timeout if the matcher hangs (its ERR state never raises `done`), and streams per-word results out on a valid/ready port. It sits between the tensor-core control path and the `matcher`, and owns the matcher's `cs` and reset.

## Interface

Parameters:
- `ADDR_WIDTH`, default 4: address width of the input and vocab buffers.
- `DATA_WIDTH`, default 8: symbol width; value 0 is the word separator.
- `TIMEOUT`, default 64: maximum RUN cycles per job before it is abandoned. Must be ≥ 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: clock.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Control:
  - `start`, in, 1: one-cycle pulse; sampled only in IDLE.
  - `in_base`, in, ADDR_WIDTH: first input address.
  - `in_limit`, in, ADDR_WIDTH: exclusive end address.
  - `vocab_start`, in, ADDR_WIDTH: vocab window start.
  - `vocab_end`, in, ADDR_WIDTH: vocab window end.
- Input buffer scan read port (combinational read, separate from the matcher's port):
  - `scan_addr`, out, ADDR_WIDTH: scan read address.
  - `scan_data`, in, DATA_WIDTH: symbol at `scan_addr`, same cycle.
- Matcher control:
  - `m_rst_n`, out, 1: registered reset to the matcher.
  - `m_cs`, out, 1: matcher chip select.
  - `m_vocab_start`, out, ADDR_WIDTH: latched vocab window start.
  - `m_vocab_end`, out, ADDR_WIDTH: latched vocab window end.
  - `m_input_start`, out, ADDR_WIDTH: start address of the current word.
  - `m_found`, in, 1: matcher found flag.
  - `m_done`, in, 1: matcher done flag.
- Result stream:
  - `res_valid`, out, 1: result available.
  - `res_ready`, in, 1: consumer accepts result.
  - `res_addr`, out, ADDR_WIDTH: word start address.
  - `res_found`, out, 1: word found in vocab.
  - `res_timeout`, out, 1: job abandoned on timeout.
- Status:
  - `busy`, out, 1: high whenever the FSM is not in IDLE.
  - `done`, out, 1: one-cycle completion pulse.
  - `word_count`, out, ADDR_WIDTH+1: number of words launched.
  - `found_count`, out, ADDR_WIDTH+1: number of words found.

## Operation

- FSM states: IDLE, SCAN, LAUNCH, RUN, RESULT, SKIP, DONE.
- IDLE:
  - `m_rst_n`=0, holding the matcher in reset.
  - On `start`: latch `in_base`, `in_limit`, `vocab_start`, `vocab_end`; set `scan_addr`=`in_base`; clear both counters; go to SCAN.
- SCAN:
  - If `scan_addr`==`in_limit`, go to DONE.
  - Else if `scan_data`==0, increment `scan_addr`.
  - Else set `m_input_start`=`scan_addr`, increment `word_count`, go to LAUNCH.
- LAUNCH: one cycle with `m_rst_n`=0, so the matcher reloads its start addresses. Clear the timeout counter. Go to RUN.
- RUN:
  - `m_rst_n`=1, `m_cs`=1; increment the timeout counter each cycle.
  - If `m_done`=1: capture `res_found`=`m_found`, `res_timeout`=0, go to RESULT.
  - Else if the counter reaches TIMEOUT: capture `res_found`=0, `res_timeout`=1, go to RESULT.
  - If `m_done` and the timeout occur in the same cycle, `m_done` wins.
- RESULT:
  - `m_rst_n`=0; `res_valid`=1, `res_addr`=`m_input_start`.
  - On `res_valid & res_ready`: increment `found_count` if `res_found`, then go to SKIP.
- SKIP:
  - If `scan_addr`==`in_limit`, go to DONE.
  - Else if `scan_data`≠0, increment `scan_addr`.
  - Else go to SCAN; the separator is skipped there.
- DONE: `done`=1 for one cycle, then go to IDLE. Counters hold until the next `start`.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. `in_base`=14, `in_limit`=2 covers addresses 14, 15, 0, 1.
- `in_base`==`in_limit` means an empty buffer: zero words.
- A word that reaches `in_limit` with no terminator is still launched. The matcher reads past the limit; this is the caller's responsibility.
- `start` outside IDLE is ignored.
- `m_vocab_start` and `m_vocab_end` are stable from latch until the next `start`.

## Timing

- Reset values of outputs:
  - All outputs 0, including `m_rst_n`=0.
  - `scan_addr`, `m_input_start`, `m_vocab_start`, `m_vocab_end` reset to 0.
  - FSM resets to IDLE.
- `m_rst_n` and `m_cs` are driven directly from flops; they carry no combinational logic.
- Result payload and `res_valid` are registered. The payload is stable while `res_valid` is high and `res_ready` is low.
- Cycle costs:
  - Per separator symbol: 1 cycle in SCAN.
  - Per word: 1 (SCAN) + 1 (LAUNCH) + N (RUN) + ≥1 (RESULT) + word length + 1 (SKIP).
  - RUN length: N ≤ TIMEOUT.
- Empty buffer: `start` at cycle 0 → SCAN at cycle 1 → DONE at cycle 2 (`done`=1) → IDLE at cycle 3.
- `rst_n` asserted in any state takes effect immediately:
  - `m_rst_n` drops asynchronously.
  - The result in flight is discarded; no `done` pulse.

## Test plan

- Two-word buffer:
  - Stimulus: buffer[0..7]={63,61,74,00,64,6F,67,00}, vocab holds "cat", base 0, limit 8.
  - Response: results (addr 0, found 1, timeout 0) then (addr 4, found 0, timeout 0); `word_count`=2, `found_count`=1, one `done` pulse.
- Empty buffer:
  - Stimulus: base=limit=5.
  - Response: `done` exactly 2 cycles after `start`; no `res_valid`; `m_cs` never asserted.
- Timeout:
  - Stimulus: matcher stub that never raises `m_done`, TIMEOUT=8.
  - Response: `res_timeout`=1 and `res_found`=0 after exactly 8 RUN cycles; `m_rst_n` low in the following cycle.
- Backpressure:
  - Stimulus: `res_ready` held low for 10 cycles.
  - Response: `res_valid` held; `res_addr`/`res_found` unchanged; `m_rst_n`=0 throughout; `found_count` increments only on the handshake.
- Wrap-around:
  - Stimulus: base 14, limit 2, buffer[14]=41, buffer[15]=00, buffer[0]=42, buffer[1]=00.
  - Response: results at addr 14 then addr 0; `done` pulse.
- Reset mid-RUN:
  - Stimulus: drop `rst_n` during RUN.
  - Response: all outputs 0 the same cycle; IDLE after release; a new `start` runs cleanly.
